// File: rtl/cic_pkg.sv
// Shared sizing and output-scaling helpers for the CIC interpolator.
// CIC_INTERP_SAT_EN clamps the rounding carry at positive full scale.
package cic_pkg;

   function automatic int acc_width(int in_w, int stages, int max_r);
      return in_w + stages * $clog2(max_r);
   endfunction

   function automatic int clog2_rt(int r);
      int n;
      n = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < r) n = i + 1;
      return n;
   endfunction

   function automatic int clamp_r(int r, int lo, int hi);
      return (r < lo) ? lo : ((r > hi) ? hi : r);
   endfunction

   function automatic int msb_pos(int r, int stages, int in_w);
      return in_w + clog2_rt(r) * (stages - 1) - 1;
   endfunction

   // acc[msb -: ow] plus the bit just below it, sign-extended to 64 bits
   function automatic logic signed [63:0] round_out(
      logic signed [63:0] acc,
      int msb,
      int ow
   );
      logic signed [63:0] sh;
      logic signed [63:0] top;
      logic signed [63:0] fs;
      logic signed [63:0] res;
      logic rb;
      sh  = acc >>> (msb - ow);
      rb  = sh[0];
      top = sh >>> 1;
      top = (top <<< (64 - ow)) >>> (64 - ow);
      fs  = (64'sd1 <<< (ow - 1)) - 64'sd1;
`ifdef CIC_INTERP_SAT_EN
      if (rb && top == fs) return fs;
`endif
      res = top + $signed({63'd0, rb});
      return (res <<< (64 - ow)) >>> (64 - ow);
   endfunction

endpackage

// File: rtl/cic_interp_ctrl.sv
// Rate control for the CIC interpolator: phase, load events,
// input hold register and sticky underrun/overrun flags.
module cic_interp_ctrl
   import cic_pkg::*;
#(
   parameter int MIN_INTERP = 2,
   parameter int MAX_INTERP = 40,
   parameter int IN_WIDTH   = 18,
   parameter int RW         = $clog2(MAX_INTERP) + 1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [RW-1:0]              interpolation,
   input  logic                       out_strobe,
   input  logic                       in_strobe,
   input  logic signed [IN_WIDTH-1:0] in_data,
   output logic                       load,
   output logic signed [IN_WIDTH-1:0] feed,
   output logic [RW-1:0]              r_eff,
   output logic                       in_req,
   output logic                       underrun,
   output logic                       overrun
);

   logic [RW-1:0]              phase;
   logic signed [IN_WIDTH-1:0] hold;
   logic                       hold_full;
   logic                       wrap;

   // a fixed-rate build collapses the clamp onto MAX_INTERP
   assign r_eff = RW'(clamp_r(int'(interpolation), MIN_INTERP, MAX_INTERP));
   assign load  = out_strobe && (phase == '0);
   assign wrap  = phase >= (r_eff - RW'(1));
   assign feed  = hold_full ? hold : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         in_req    <= 1'b0;
         underrun  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         in_req <= load;
         if (out_strobe)
            phase <= wrap ? '0 : phase + RW'(1);
         if (load && !hold_full)
            underrun <= 1'b1;
         if (in_strobe) begin
            hold      <= in_data;
            hold_full <= 1'b1;
            if (hold_full && !load)
               overrun <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator: combs at the input rate, zero-stuffed integrators at
// the out_strobe rate. Define CIC_INTERP_SAT_EN to clamp the rounding carry.
module cic_interp
   import cic_pkg::*;
#(
   parameter int STAGES     = 5,
   parameter int MIN_INTERP = 2,
   parameter int MAX_INTERP = 40,
   parameter int IN_WIDTH   = 18,
   parameter int OUT_WIDTH  = 18,
   parameter int ACC_WIDTH  = acc_width(IN_WIDTH, STAGES, MAX_INTERP)
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [$clog2(MAX_INTERP):0]   interpolation,
   input  logic                          out_strobe,
   output logic                          in_req,
   input  logic                          in_strobe,
   input  logic signed [IN_WIDTH-1:0]    in_data,
   output logic signed [OUT_WIDTH-1:0]   out_data,
   output logic                          out_valid,
   output logic                          underrun,
   output logic                          overrun
);

   localparam int RW = $clog2(MAX_INTERP) + 1;

   logic                        load;
   logic signed [IN_WIDTH-1:0]  feed;
   logic [RW-1:0]               r_eff;
   logic signed [ACC_WIDTH-1:0] x;
   logic signed [ACC_WIDTH-1:0] cm    [STAGES];
   logic signed [ACC_WIDTH-1:0] dly   [STAGES];
   logic signed [ACC_WIDTH-1:0] integ [STAGES];

   cic_interp_ctrl #(
      .MIN_INTERP (MIN_INTERP),
      .MAX_INTERP (MAX_INTERP),
      .IN_WIDTH   (IN_WIDTH),
      .RW         (RW)
   ) u_ctrl (
      .clock         (clock),
      .reset_n       (reset_n),
      .interpolation (interpolation),
      .out_strobe    (out_strobe),
      .in_strobe     (in_strobe),
      .in_data       (in_data),
      .load          (load),
      .feed          (feed),
      .r_eff         (r_eff),
      .in_req        (in_req),
      .underrun      (underrun),
      .overrun       (overrun)
   );

   assign x = ACC_WIDTH'(feed);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            cm[k]    <= '0;
            dly[k]   <= '0;
            integ[k] <= '0;
         end
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_strobe;
         if (load) begin
            cm[0]  <= x - dly[0];
            dly[0] <= x;
            for (int k = 1; k < STAGES; k++) begin
               cm[k]  <= cm[k-1] - dly[k];
               dly[k] <= cm[k-1];
            end
         end
         // zero-stuffing: the comb output enters only on load events
         if (out_strobe) begin
            integ[0] <= integ[0] + (load ? cm[STAGES-1] : '0);
            for (int k = 1; k < STAGES; k++)
               integ[k] <= integ[k] + integ[k-1];
            out_data <= OUT_WIDTH'(round_out(64'(integ[STAGES-1]),
                           msb_pos(int'(r_eff), STAGES, IN_WIDTH), OUT_WIDTH));
         end
      end
   end

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp against a sample-history reference.
// Honours CIC_INTERP_SAT_EN when the design is built with it.
module tb_cic_interp;
   import cic_pkg::*;

   localparam int S    = 5;
   localparam int IW   = 18;
   localparam int OW   = 18;
   localparam int MINR = 2;
   localparam int MAXR = 40;
   localparam int RW   = $clog2(MAXR) + 1;
   localparam int AW   = IW + S * $clog2(MAXR);

   logic clock = 1'b0;
   logic reset_n = 1'b1;
   logic [RW-1:0] interpolation = '0;
   logic out_strobe = 1'b0;
   logic in_strobe = 1'b0;
   logic signed [IW-1:0] in_data = '0;
   logic in_req, out_valid, underrun, overrun;
   logic signed [OW-1:0] out_data;

   int checks = 0;
   int failures = 0;

   cic_interp #(
      .STAGES(S), .MIN_INTERP(MINR), .MAX_INTERP(MAXR),
      .IN_WIDTH(IW), .OUT_WIDTH(OW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .interpolation(interpolation),
      .out_strobe(out_strobe), .in_req(in_req), .in_strobe(in_strobe),
      .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
      .underrun(underrun), .overrun(overrun)
   );

   always #5 clock = ~clock;

   // stimulus controls
   bit supply, skip_one, rnd_data, rnd_extra, os_en;
   int stride, os_cnt, nreq, nvalid;
   longint dc_val;

   // reference model state
   int m_phase;
   longint m_hold;
   bit m_hf, m_under, m_over, e_req, e_valid;
   longint e_out;
   longint mi[S];
   longint xs[$];

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint wrap_acc(longint v);
      return (v <<< (64 - AW)) >>> (64 - AW);
   endfunction

   function automatic longint binom(int n, int k);
      longint b = 1;
      for (int i = 0; i < k; i++) b = b * (n - i) / (i + 1);
      return b;
   endfunction

   // S-th difference of the fed samples, delayed by S load events
   function automatic longint comb_out();
      longint s = 0;
      int n = xs.size();
      for (int j = 0; j <= S; j++) begin
         int idx = n - S - j;
         if (idx >= 0)
            s += ((j % 2) ? -binom(S, j) : binom(S, j)) * xs[idx];
      end
      return s;
   endfunction

   // floor((v + half LSB) / LSB), keeping OW bits
   function automatic longint exp_round(longint acc, int r);
      int msb = IW + $clog2(r) * (S - 1) - 1;
      longint v = (acc <<< (63 - msb)) >>> (63 - msb);
      longint q = (v + (longint'(1) <<< (msb - OW))) >>> (msb - OW + 1);
`ifdef CIC_INTERP_SAT_EN
      if (q > 131071) q = 131071;
`endif
      return (q <<< (64 - OW)) >>> (64 - OW);
   endfunction

   function automatic void model_reset();
      m_phase = 0; m_hold = 0; m_hf = 0; m_under = 0; m_over = 0;
      e_req = 0; e_valid = 0; e_out = 0;
      for (int k = 0; k < S; k++) mi[k] = 0;
      xs.delete();
   endfunction

   function automatic void model_step();
      int ri = int'(interpolation);
      int r = (ri < MINR) ? MINR : ((ri > MAXR) ? MAXR : ri);
      bit load = out_strobe && (m_phase == 0);
      longint feed = m_hf ? m_hold : 0;
      e_req = load;
      e_valid = out_strobe;
      if (load && !m_hf) m_under = 1;
      if (out_strobe) begin
         longint cv = load ? comb_out() : 0;
         e_out = exp_round(mi[S-1], r);
         for (int k = S - 1; k > 0; k--) mi[k] = wrap_acc(mi[k] + mi[k-1]);
         mi[0] = wrap_acc(mi[0] + cv);
         m_phase = (m_phase >= r - 1) ? 0 : m_phase + 1;
      end
      if (load) xs.push_back(feed);
      if (in_strobe) begin
         if (m_hf && !load) m_over = 1;
         m_hold = longint'(in_data);
         m_hf = 1;
      end else if (load) begin
         m_hf = 0;
      end
   endfunction

   function automatic logic signed [IW-1:0] next_data();
      if (rnd_data) return IW'($urandom);
      return IW'(dc_val);
   endfunction

   task automatic tick();
      model_step();
      @(posedge clock); #1;
      chk("in_req", in_req, e_req);
      chk("out_valid", out_valid, e_valid);
      chk("out_data", out_data, e_out);
      chk("underrun", underrun, m_under);
      chk("overrun", overrun, m_over);
      if (in_req) nreq++;
      if (out_valid) nvalid++;
      in_strobe = 0;
      if (in_req && supply) begin
         if (skip_one) skip_one = 0;
         else begin in_strobe = 1; in_data = next_data(); end
      end
      if (rnd_extra && !in_strobe && $urandom_range(0, 15) == 0) begin
         in_strobe = 1; in_data = next_data();
      end
      if (!os_en) out_strobe = 0;
      else if (stride == 0) out_strobe = ($urandom_range(0, 1) == 1);
      else begin
         os_cnt = (os_cnt + 1 >= stride) ? 0 : os_cnt + 1;
         out_strobe = (os_cnt == 0);
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      in_strobe = 0; out_strobe = 0;
      reset_n = 0;
      #2;
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_req", in_req, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_overrun", overrun, 0);
      model_reset();
      @(posedge clock); #1;
      reset_n = 1;
      os_cnt = 0; skip_one = 0; rnd_extra = 0;
   endtask

   task automatic preload();
      in_strobe = 1; in_data = next_data(); tick();
   endtask

   initial begin
      bit reached;
      logic signed [63:0] rv, rexp;
      supply = 0; skip_one = 0; rnd_data = 0; rnd_extra = 0; os_en = 0;
      stride = 3; os_cnt = 0; nreq = 0; nvalid = 0; dc_val = 0;
      #1;
      do_reset();

      // DC through a power-of-two factor
      interpolation = 4; dc_val = 1000; supply = 1; os_en = 1; stride = 3;
      preload(); run(400);
      chk("dc4_settled", out_data, 1000);
      nreq = 0; nvalid = 0; run(144);
      chk("dc4_req_count", nreq, 12);
      chk("dc4_valid_count", nvalid, 48);
      chk("dc4_still", out_data, 1000);

      // DC through a non-power-of-two factor
      do_reset();
      interpolation = 5; supply = 1; os_en = 1; stride = 3;
      preload(); run(700);
      chk("dc5_settled", out_data, 153);

      // one withheld sample
      skip_one = 1; run(100);
      chk("underrun_set", underrun, 1);
      run(600);
      chk("underrun_sticky", underrun, 1);
      chk("underrun_recover", out_data, 153);

      // overrun: two strobes with no load between them
      do_reset();
      os_en = 0; supply = 0;
      in_strobe = 1; in_data = 500; tick();
      chk("ovr_first", overrun, 0);
      in_strobe = 1; in_data = 600; tick();
      chk("ovr_second", overrun, 1);

      // strobe coincident with a consuming load keeps the hold full
      do_reset();
      interpolation = 4; os_en = 0; supply = 0;
      in_strobe = 1; in_data = 700; tick();
      in_strobe = 1; in_data = 800; out_strobe = 1; tick();
      chk("coinc_overrun", overrun, 0);
      chk("coinc_req", in_req, 1);
      for (int i = 0; i < 4; i++) begin out_strobe = 1; tick(); end
      chk("coinc_next_req", in_req, 1);
      chk("coinc_no_underrun", underrun, 0);

      // rate change 8 -> 2 at phase 5
      do_reset();
      interpolation = 8; dc_val = 1000; supply = 1; os_en = 1; stride = 3;
      preload();
      reached = 0;
      for (int i = 0; i < 300 && !reached; i++) begin
         tick();
         if (e_valid && m_phase == 5) reached = 1;
      end
      chk("rate_sync", reached, 1);
      interpolation = 2; nreq = 0;
      run(25);
      chk("rate_req_spacing", nreq, 4);

      // full scale, then a gain jump that overflows the output slice
      do_reset();
      interpolation = 5; dc_val = 131071; supply = 1; os_en = 1; stride = 3;
      preload(); run(700);
      interpolation = 4; run(300);
      rv = round_out((64'sd131071 <<< 8) + 64'sd128, 25, OW);
`ifdef CIC_INTERP_SAT_EN
      rexp = 131071;
`else
      rexp = -131072;
`endif
      chk("round_carry", rv, rexp);
      rv = round_out((64'sd1000 <<< 8) + 64'sd127, 25, OW);
      chk("round_down", rv, 1000);
      rv = round_out(-64'sd256000 + 64'sd128, 25, OW);
      chk("round_half_neg", rv, -999);

      // randomized data, strobes and factors, with a mid-run reset
      do_reset();
      rnd_data = 1; supply = 1; os_en = 1; stride = 0;
      for (int seg = 0; seg < 4; seg++) begin
         rnd_extra = 1;
         interpolation = RW'($urandom_range(0, 127));
         run(300);
         if (seg == 1) begin
            do_reset();
            rnd_data = 1;
         end
      end
      stride = 1; interpolation = 2; rnd_extra = 0;
      run(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
